// File: rtl/subterranean_hash_axi4_lite_master.sv
// Subterranean hash sequencer driving the core's AXI4-Lite slave port.
// Optional: SUBTERRANEAN_HASH_RESP_CHECK_EN aborts on bad bresp/rresp.
module subterranean_hash_axi4_lite_master #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DIGEST_BYTES = 32,
    parameter int BLANK_ROUNDS = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic                  empty_msg,
    input  logic [7:0]            msg_tdata,
    input  logic                  msg_tvalid,
    output logic                  msg_tready,
    input  logic                  msg_tlast,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [255:0]          digest,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [31:0]           m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);
    localparam int NWORDS = DIGEST_BYTES / 4;
    localparam logic [3:0] LAST_K = 4'(NWORDS - 1);
    localparam logic [15:0] LAST_BLANK = 16'(BLANK_ROUNDS - 1);
    localparam logic [ADDR_WIDTH-1:0] A_INIT = '0;
    localparam logic [ADDR_WIDTH-1:0] A_DUP1 = ADDR_WIDTH'(8'h24);
    localparam logic [ADDR_WIDTH-1:0] A_DUP = ADDR_WIDTH'(8'h20);
    localparam logic [ADDR_WIDTH-1:0] A_SQZ = ADDR_WIDTH'(8'h70);
    localparam logic [ADDR_WIDTH-1:0] A_READ = ADDR_WIDTH'(8'h80);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_WAIT_BYTE, S_ABS, S_EMPTY1,
        S_PAD, S_BLANK, S_SQZ_W, S_SQZ_R, S_DONE
    } state_t;

    typedef enum logic [1:0] {P_START, P_ADDR, P_RESP} phase_t;

    state_t state;
    state_t wr_next;
    phase_t phase;
    logic empty_q;
    logic last_q;
    logic [7:0] byte_q;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic [3:0] k;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0] wr_data;
    logic b_bad;
    logic r_bad;

`ifdef SUBTERRANEAN_HASH_RESP_CHECK_EN
    assign b_bad = (m_axi_bresp != 2'b00);
    assign r_bad = (m_axi_rresp != 2'b00);
`else
    logic unused_resp;
    assign unused_resp = ^{m_axi_bresp, m_axi_rresp};
    assign b_bad = 1'b0;
    assign r_bad = 1'b0;
`endif

    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;

    // Address, data and successor state of the write owned by the current state
    always_comb begin
        wr_addr = A_INIT;
        wr_data = 32'h1;
        wr_next = state;
        cnt_nxt = '0;
        unique case (state)
            S_INIT: begin
                wr_data = '0;
                wr_next = empty_q ? S_PAD : S_WAIT_BYTE;
            end
            S_ABS: begin
                wr_addr = A_DUP1;
                wr_data = {23'b0, 1'b1, byte_q};
                wr_next = S_EMPTY1;
            end
            S_EMPTY1: begin
                wr_addr = A_DUP;
                wr_next = last_q ? S_PAD : S_WAIT_BYTE;
            end
            S_PAD: begin
                wr_addr = A_DUP;
                if (cnt == 16'd1) begin
                    wr_next = (BLANK_ROUNDS == 0) ? S_SQZ_W : S_BLANK;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            S_BLANK: begin
                wr_addr = A_DUP;
                if (cnt == LAST_BLANK) begin
                    wr_next = S_SQZ_W;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            S_SQZ_W: begin
                wr_addr = A_SQZ;
                wr_next = S_SQZ_R;
            end
            default: ;
        endcase
    end

    // Sequencer with embedded write and read bus engines
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= S_IDLE;
            phase <= P_START;
            empty_q <= 1'b0;
            last_q <= 1'b0;
            byte_q <= '0;
            cnt <= '0;
            k <= '0;
            msg_tready <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            error <= 1'b0;
            digest <= '0;
            m_axi_awaddr <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata <= '0;
            m_axi_wstrb <= '0;
            m_axi_wvalid <= 1'b0;
            m_axi_bready <= 1'b0;
            m_axi_araddr <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        error <= 1'b0;
                        digest <= '0;
                        k <= '0;
                        cnt <= '0;
                        empty_q <= empty_msg;
                        phase <= P_START;
                        state <= S_INIT;
                    end
                end
                S_WAIT_BYTE: begin
                    if (msg_tvalid && msg_tready) begin
                        msg_tready <= 1'b0;
                        byte_q <= msg_tdata;
                        last_q <= msg_tlast;
                        phase <= P_START;
                        state <= S_ABS;
                    end
                end
                S_DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    state <= S_IDLE;
                end
                S_SQZ_R: begin
                    unique case (phase)
                        P_START: begin
                            m_axi_araddr <= A_READ;
                            m_axi_arvalid <= 1'b1;
                            phase <= P_ADDR;
                        end
                        P_ADDR: begin
                            if (m_axi_arready) begin
                                m_axi_arvalid <= 1'b0;
                                m_axi_rready <= 1'b1;
                                phase <= P_RESP;
                            end
                        end
                        P_RESP: begin
                            if (m_axi_rvalid) begin
                                m_axi_rready <= 1'b0;
                                digest[{k[2:0], 5'b00000} +: 32] <= m_axi_rdata;
                                k <= k + 4'd1;
                                phase <= P_START;
                                if (r_bad) begin
                                    error <= 1'b1;
                                    state <= S_DONE;
                                end else if (k == LAST_K) begin
                                    state <= S_DONE;
                                end else begin
                                    state <= S_SQZ_W;
                                end
                            end
                        end
                        default: phase <= P_START;
                    endcase
                end
                default: begin
                    unique case (phase)
                        P_START: begin
                            m_axi_awaddr <= wr_addr;
                            m_axi_wdata <= wr_data;
                            m_axi_wstrb <= 4'hF;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid <= 1'b1;
                            phase <= P_ADDR;
                        end
                        P_ADDR: begin
                            if (m_axi_awready) m_axi_awvalid <= 1'b0;
                            if (m_axi_wready) m_axi_wvalid <= 1'b0;
                            if ((!m_axi_awvalid || m_axi_awready) &&
                                (!m_axi_wvalid || m_axi_wready)) begin
                                m_axi_bready <= 1'b1;
                                phase <= P_RESP;
                            end
                        end
                        P_RESP: begin
                            if (m_axi_bvalid) begin
                                m_axi_bready <= 1'b0;
                                phase <= P_START;
                                if (b_bad) begin
                                    error <= 1'b1;
                                    state <= S_DONE;
                                end else begin
                                    cnt <= cnt_nxt;
                                    msg_tready <= (wr_next == S_WAIT_BYTE);
                                    state <= wr_next;
                                end
                            end
                        end
                        default: phase <= P_START;
                    endcase
                end
            endcase
        end
    end
endmodule

// File: doc/subterranean_hash_axi4_lite_master.md
Name: subterranean_hash_axi4_lite_master

Overview:
- Upstream sequencer for `subterranean_simple_axi4_lite`.
- Accepts a message as a byte stream and drives the core's AXI4-Lite slave port through the full Subterranean hash sequence: init, per-byte absorb, blank rounds, then squeeze.
- Collects a 256-bit digest and presents it to the system.
- Replaces the software/bench-driven register sequence with hardware.

Parameters:
- `ADDR_WIDTH`, 8, AXI4-Lite address width.
- `DIGEST_BYTES`, 32, digest length in bytes; must be a multiple of 4, max 32.
- `BLANK_ROUNDS`, 8, empty duplex calls after the two post-message empty duplex calls.

Ports:
- `aclk` in 1: clock.
- `aresetn` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle pulse, begin hash; ignored unless idle.
- `empty_msg` in 1: sampled with `start`; 1 = zero-length message, no bytes follow.
- `msg_tdata` in 8: message byte.
- `msg_tvalid` in 1: byte valid.
- `msg_tready` out 1: byte accepted when `msg_tvalid && msg_tready`.
- `msg_tlast` in 1: marks the final message byte.
- `busy` out 1: high from accepted `start` until DONE.
- `done` out 1: one-cycle pulse, digest valid.
- `error` out 1: sticky response error, cleared on next `start`.
- `digest` out 256: word k (read k) at bits [32k+31:32k]; unused upper bits 0.
- `m_axi_awaddr` out `ADDR_WIDTH`; `m_axi_awprot` out 3; `m_axi_awvalid` out 1; `m_axi_awready` in 1.
- `m_axi_wdata` out 32; `m_axi_wstrb` out 4; `m_axi_wvalid` out 1; `m_axi_wready` in 1.
- `m_axi_bresp` in 2; `m_axi_bvalid` in 1; `m_axi_bready` out 1.
- `m_axi_araddr` out `ADDR_WIDTH`; `m_axi_arprot` out 3; `m_axi_arvalid` out 1; `m_axi_arready` in 1.
- `m_axi_rdata` in 32; `m_axi_rresp` in 2; `m_axi_rvalid` in 1; `m_axi_rready` out 1.

Behaviour:
- Reset (async, `aresetn` = 0):
  - State = IDLE.
  - All valid/ready outputs 0; addresses, data, `wstrb` 0.
  - `prot` always 3'b000.
  - `busy`, `done`, `error` 0; `digest` 0; counters 0.
  - Reset mid-transaction abandons the transaction immediately, with no completion.
- Write engine:
  - Asserts `awvalid` and `wvalid` in the same cycle; `wstrb` = 4'hF.
  - Each valid drops independently the cycle after its own handshake.
  - Once both handshakes are done, `bready` = 1 until `bvalid`; one idle cycle follows before the next operation.
- Read engine:
  - `arvalid` is held until `arready`.
  - Then `rready` = 1 until `rvalid`, capturing `rdata` that cycle.
- State sequence:
  - IDLE -> INIT on `start`.
  - INIT: write addr 0x00, data 0.
  - Then WAIT_BYTE, or PAD if `empty_msg`.
  - WAIT_BYTE: `msg_tready` = 1 only here; on handshake, latch byte and `tlast` -> ABS.
  - ABS: write addr 0x24 (1-byte duplex), data {23'b0, 1'b1, byte} -> EMPTY1.
  - EMPTY1: write addr 0x20, data 32'h1 -> WAIT_BYTE, or PAD if latched `tlast`.
  - PAD: two writes addr 0x20, data 32'h1 -> BLANK.
  - BLANK: `BLANK_ROUNDS` writes addr 0x20, data 32'h1 -> SQZ_W.
  - SQZ_W: write addr 0x70, data 32'h1 -> SQZ_R.
  - SQZ_R: read addr 0x80, store into digest word k, k++.
  - Loop to SQZ_W until k = `DIGEST_BYTES`/4 -> DONE.
  - DONE: `done` pulse for 1 cycle, `busy` 0 -> IDLE.
- `digest` holds its value until the next accepted `start`, which clears it to 0.
- `msg_tvalid` while not in WAIT_BYTE: stalled, not dropped.
- `start` while busy: ignored.
- Byte counter is unbounded: any message length is supported.
- `tlast` on the first byte gives a 1-byte message.
- `bresp`/`rresp` handling depends on the optional feature below.

Optional Feature:
- Macro: `SUBTERRANEAN_HASH_RESP_CHECK_EN`.
- Defined:
  - `bresp` or `rresp` != 2'b00 sets `error`.
  - FSM aborts to DONE after the current transaction completes (`done` still pulses).
  - `digest` words not yet read stay 0.
- Undefined:
  - Responses are ignored.
  - `error` is tied 0.

Test Plan:
- `empty_msg`=1, `start` -> exact AXI write sequence: 0x00/0x0, then 10x 0x20/0x1, then 8x (0x70/0x1 write, 0x80 read).
  - `digest` matches `LWC_HASH_KAT_256.txt` Count=1.
  - `done` pulses once.
- 1-byte message 0xA5, `tlast` -> writes: 0x00/0x0, 0x24/0x000001A5, 0x20/0x1, then 10x 0x20/0x1, then squeeze.
  - `digest` matches the Subterranean C reference model for message A5.
- 3-byte message 00 01 02 with `msg_tvalid` gapped by 5 cycles -> `msg_tready` high only in WAIT_BYTE.
  - Three 0x24 writes with data 0x100, 0x101, 0x102; `digest` = KAT Count=4.
- Slave delays `awready` 3 cycles, `wready` immediate, `bvalid` 2 cycles later -> `wvalid` drops after 1 cycle, `awvalid` held 4 cycles, exactly one write per operation, correct digest.
- `aresetn` pulsed low during the 3rd squeeze read -> all outputs 0 asynchronously.
  - A following `start` with KAT Count=1 completes correctly.
- With `SUBTERRANEAN_HASH_RESP_CHECK_EN`: `bresp`=2'b10 on the INIT write -> `error`=1, `done` pulse, no further writes, `digest`=0.
  - Without the macro: same stimulus -> `error`=0, full sequence runs.
